// File: rtl/per_gpio_pkg.sv
// Shared definitions for the GPIO peripheral: register byte offsets and bus width.
package per_gpio_pkg;

  localparam int BUS_W = 32;

  localparam logic [15:0] REG_OUT     = 16'h0000;
  localparam logic [15:0] REG_OUT_SET = 16'h0004;
  localparam logic [15:0] REG_OUT_CLR = 16'h0008;
  localparam logic [15:0] REG_OUT_TGL = 16'h000C;
  localparam logic [15:0] REG_IN      = 16'h0010;
  localparam logic [15:0] REG_OE      = 16'h0014;
  localparam logic [15:0] REG_RISE_EN = 16'h0018;
  localparam logic [15:0] REG_FALL_EN = 16'h001C;
  localparam logic [15:0] REG_FLAGS   = 16'h0020;
  localparam logic [15:0] REG_PARAM   = 16'h0024;

endpackage

// File: rtl/per_gpio_sync.sv
// Multi-stage input synchroniser with a trailing previous-sample register,
// usable by any peripheral that needs edge detection on asynchronous inputs.
module per_gpio_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] prev_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = stage_q[SYNC_STAGES-1];
  assign prev_o = prev_q;

endmodule

// File: rtl/per_gpio_irq.sv
// GPIO peripheral: output/OE registers with set/clear/toggle aliases, synchronised
// inputs, per-pin rise/fall edge flags (write-1-to-clear) and a level interrupt.
module per_gpio_irq
  import per_gpio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [15:0]      addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  input  logic [1:0]       size_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] gpio_in_i,
  output logic [WIDTH-1:0] gpio_out_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  // Bus protocol: rd_i/wr_i are single-cycle strobes sampled at the clk_i edge;
  // there is no backpressure, every strobe completes in that cycle.
  logic [WIDTH-1:0] out_q, oe_q, rise_en_q, fall_en_q, flags_q;
  logic [WIDTH-1:0] out_nxt, flags_nxt, w1c;
  logic [WIDTH-1:0] in_sync, in_prev, rise, fall;
  logic [WIDTH-1:0] wdata_w;
  logic [BUS_W-1:0] rd_mux;
  logic             unused;

  assign wdata_w = wdata_i[WIDTH-1:0];
  assign unused  = ^{size_i, wdata_i};

  per_gpio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .d_i      (gpio_in_i),
    .sync_o   (in_sync),
    .prev_o   (in_prev)
  );

  assign rise = in_sync & ~in_prev & rise_en_q;
  assign fall = ~in_sync & in_prev & fall_en_q;

  always_comb begin
    out_nxt = out_q;
    if (wr_i) begin
      case (addr_i)
        REG_OUT:     out_nxt = wdata_w;
        REG_OUT_SET: out_nxt = out_q | wdata_w;
        REG_OUT_CLR: out_nxt = out_q & ~wdata_w;
        REG_OUT_TGL: out_nxt = out_q ^ wdata_w;
        default:     out_nxt = out_q;
      endcase
    end
  end

  // A newly detected edge overrides a simultaneous clear of the same bit.
  assign w1c       = (wr_i && addr_i == REG_FLAGS) ? wdata_w : '0;
  assign flags_nxt = (flags_q & ~w1c) | rise | fall;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_q     <= OUT_RESET;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      flags_q   <= '0;
    end else begin
      out_q   <= out_nxt;
      flags_q <= flags_nxt;
      if (wr_i && addr_i == REG_OE)      oe_q      <= wdata_w;
      if (wr_i && addr_i == REG_RISE_EN) rise_en_q <= wdata_w;
      if (wr_i && addr_i == REG_FALL_EN) fall_en_q <= wdata_w;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      REG_OUT:     rd_mux[WIDTH-1:0] = out_q;
      REG_IN:      rd_mux[WIDTH-1:0] = in_sync;
      REG_OE:      rd_mux[WIDTH-1:0] = oe_q;
      REG_RISE_EN: rd_mux[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN: rd_mux[WIDTH-1:0] = fall_en_q;
      REG_FLAGS:   rd_mux[WIDTH-1:0] = flags_q;
      REG_PARAM:   rd_mux = {16'h0, 8'(SYNC_STAGES), 8'(WIDTH)};
      default:     rd_mux = '0;
    endcase
  end

  // Registered read sees pre-write register state when rd_i and wr_i coincide.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  rdata_o <= '0;
    else if (rd_i)   rdata_o <= rd_mux;
  end

  assign gpio_out_o = out_q;
  assign gpio_oe_o  = oe_q;
  assign irq_o      = |flags_q;

endmodule

// File: tb/tb_per_gpio_irq.sv
// Directed bench for per_gpio_irq: a 32-pin instance for register/edge behaviour
// and an 8-pin instance for width masking and the PARAM register.
module tb_per_gpio_irq;
  import per_gpio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  size = 2'b10;

  logic [15:0] addr_a = '0, addr_b = '0;
  logic [31:0] wdata_a = '0, wdata_b = '0;
  logic        rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;

  logic [31:0] gin_a = '0, gout_a, goe_a, rdata_a;
  logic        irq_a;
  logic [7:0]  gin_b = '0, gout_b, goe_b;
  logic [31:0] rdata_b;
  logic        irq_b;

  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  per_gpio_irq #(.WIDTH(32), .SYNC_STAGES(2), .OUT_RESET(32'h0)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .addr_i(addr_a), .wdata_i(wdata_a),
    .rdata_o(rdata_a), .size_i(size), .rd_i(rd_a), .wr_i(wr_a),
    .gpio_in_i(gin_a), .gpio_out_o(gout_a), .gpio_oe_o(goe_a), .irq_o(irq_a)
  );

  per_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2), .OUT_RESET(8'h0)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .addr_i(addr_b), .wdata_i(wdata_b),
    .rdata_o(rdata_b), .size_i(size), .rd_i(rd_b), .wr_i(wr_b),
    .gpio_in_i(gin_b), .gpio_out_o(gout_b), .gpio_oe_o(goe_b), .irq_o(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input bit b, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    if (b) begin addr_b = a; wdata_b = d; wr_b = 1'b1; end
    else   begin addr_a = a; wdata_a = d; wr_a = 1'b1; end
    @(negedge clk);
    wr_a = 1'b0;
    wr_b = 1'b0;
  endtask

  task automatic bus_read(input bit b, input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    if (b) begin addr_b = a; rd_b = 1'b1; end
    else   begin addr_a = a; rd_a = 1'b1; end
    @(negedge clk);
    rd_a = 1'b0;
    rd_b = 1'b0;
    d = b ? rdata_b : rdata_a;
  endtask

  task automatic chk_read(input bit b, input logic [15:0] a, input logic [31:0] exp,
                          input string tag);
    logic [31:0] v;
    bus_read(b, a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out", gout_a, 32'h0);
    chk("rst_oe", goe_a, 32'h0);
    chk("rst_irq", {31'h0, irq_a}, 32'h0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk_read(1'b0, REG_PARAM, 32'h0000_0220, "param32");

    // Output register and its set/clear/toggle aliases
    bus_write(1'b0, REG_OUT, 32'hF0);
    bus_write(1'b0, REG_OUT_SET, 32'h0F);
    bus_write(1'b0, REG_OUT_CLR, 32'h30);
    bus_write(1'b0, REG_OUT_TGL, 32'h81);
    chk_read(1'b0, REG_OUT, 32'h0000_004E, "out_rd");
    chk("out_pin", gout_a, 32'h0000_004E);
    chk_read(1'b0, REG_OUT_SET, 32'h0, "wo_reads0");

    // Rising edge on pin 0: flag two edges after capture, then W1C
    bus_write(1'b0, REG_RISE_EN, 32'h1);
    @(negedge clk);
    gin_a[0] = 1'b1;
    @(posedge clk);            // E: pin captured into first stage
    @(posedge clk); #1;        // E+1
    chk("irq_e1", {31'h0, irq_a}, 32'h0);
    @(posedge clk); #1;        // E+2
    chk("irq_e2", {31'h0, irq_a}, 32'h1);
    chk_read(1'b0, REG_FLAGS, 32'h1, "flags_rise0");
    bus_write(1'b0, REG_FLAGS, 32'h1);
    chk("irq_w1c", {31'h0, irq_a}, 32'h0);
    chk_read(1'b0, REG_IN, 32'h1, "in_rd");

    // Pin 3: W1C coinciding with a new rising edge keeps the flag
    bus_write(1'b0, REG_RISE_EN, 32'h9);
    @(negedge clk);
    gin_a[3] = 1'b1;
    repeat (4) @(negedge clk);
    chk_read(1'b0, REG_FLAGS, 32'h8, "flags_rise3");
    bus_write(1'b0, REG_FLAGS, 32'h0);
    chk_read(1'b0, REG_FLAGS, 32'h8, "w1c_zero_noop");
    gin_a[3] = 1'b0;
    repeat (4) @(negedge clk);
    gin_a[3] = 1'b1;           // captured at the next edge E
    @(negedge clk);            // after E; write strobe lands on E+2
    bus_write(1'b0, REG_FLAGS, 32'h8);
    chk("irq_race", {31'h0, irq_a}, 32'h1);
    chk_read(1'b0, REG_FLAGS, 32'h8, "flags_race");
    bus_write(1'b0, REG_FLAGS, 32'h8);
    chk_read(1'b0, REG_FLAGS, 32'h0, "flags_cleared");

    // One-cycle pulse on pin 2 with both edge enables
    bus_write(1'b0, REG_RISE_EN, 32'h4);
    bus_write(1'b0, REG_FALL_EN, 32'h4);
    @(negedge clk);
    gin_a[2] = 1'b1;
    @(negedge clk);
    gin_a[2] = 1'b0;
    repeat (5) @(negedge clk);
    chk_read(1'b0, REG_FLAGS, 32'h4, "pulse_flag");
    bus_write(1'b0, REG_FLAGS, 32'h4);
    repeat (3) @(negedge clk);
    chk_read(1'b0, REG_FLAGS, 32'h0, "pulse_once");
    @(negedge clk);
    gin_a[2] = 1'b1;
    @(negedge clk);
    gin_a[2] = 1'b0;
    repeat (5) @(negedge clk);
    bus_write(1'b0, REG_FALL_EN, 32'h0);
    bus_write(1'b0, REG_RISE_EN, 32'h0);
    chk_read(1'b0, REG_FLAGS, 32'h4, "flag_kept");
    chk("irq_kept", {31'h0, irq_a}, 32'h1);

    // Narrow instance: unused bits read 0, PARAM, unmapped offset
    bus_write(1'b1, REG_OUT, 32'hFFFF_FFFF);
    chk_read(1'b1, REG_OUT, 32'h0000_00FF, "w8_out");
    chk("w8_pin", {24'h0, gout_b}, 32'h0000_00FF);
    chk_read(1'b1, REG_PARAM, 32'h0000_0208, "w8_param");
    chk_read(1'b1, 16'h0100, 32'h0, "w8_unmapped");

    // Asynchronous reset mid-cycle with state non-zero
    bus_write(1'b0, REG_OE, 32'h5A);
    chk("oe_pin", goe_a, 32'h5A);
    chk_read(1'b0, REG_OUT, 32'h0000_004E, "out_before_rst");
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", gout_a, 32'h0);
    chk("arst_oe", goe_a, 32'h0);
    chk("arst_irq", {31'h0, irq_a}, 32'h0);
    chk("arst_rdata", rdata_a, 32'h0);
    chk("arst_out8", {24'h0, gout_b}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
